// File: rtl/pu_psum_accum_if.sv
// Handshake bundle between the MAC adder trees, the psum accumulator and the result memory.
// Carries the input beat channel, the output result channel and the cache-clear control.
// The slave modport is the accumulator's view; the master modport is the producer/consumer view.
interface pu_psum_accum_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CH      = 4,
  parameter int PSUM_WIDTH  = 2*DATA_WIDTH+6,
  parameter int CADDR_WIDTH = 5
);
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_CH*PSUM_WIDTH-1:0]  in_psum;
  logic [CADDR_WIDTH-1:0]        in_addr;
  logic                          in_first;
  logic                          in_last;
  logic                          in_add_bias;
  logic                          in_relu;
  logic [3:0]                    in_shift;
  logic [NUM_CH*DATA_WIDTH-1:0]  in_bias;
  logic                          in_cache_clear;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_CH*DATA_WIDTH-1:0]  out_data;
  logic [CADDR_WIDTH-1:0]        out_addr;
  logic [NUM_CH-1:0]             out_sat;
  logic                          out_clear_busy;

  modport slave (
    input  in_valid, in_psum, in_addr, in_first, in_last, in_add_bias,
           in_relu, in_shift, in_bias, in_cache_clear, out_ready,
    output in_ready, out_valid, out_data, out_addr, out_sat, out_clear_busy
  );

  modport master (
    output in_valid, in_psum, in_addr, in_first, in_last, in_add_bias,
           in_relu, in_shift, in_bias, in_cache_clear, out_ready,
    input  in_ready, out_valid, out_data, out_addr, out_sat, out_clear_busy
  );
endinterface

// File: rtl/pu_psum_accum.sv
// Multi-channel partial-sum accumulator with bias, rounding shift, ReLU and saturation on the last pass.
// Latency: cache update at the accept edge; result valid one cycle after the last beat is accepted.
// Backpressure: in_ready drops while clearing, on a clear request, or when a held output is not consumed.
module pu_psum_accum #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CH      = 4,
  parameter int PSUM_WIDTH  = 2*DATA_WIDTH+6,
  parameter int ACC_WIDTH   = PSUM_WIDTH+4,
  parameter int CACHE_DEPTH = 32,
  parameter int CADDR_WIDTH = 5
) (
  input logic            clk,
  input logic            rst,
  pu_psum_accum_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  localparam int                     EW         = NUM_CH*ACC_WIDTH;
  localparam logic [31:0]            DEPTH_U    = 32'(CACHE_DEPTH);
  localparam logic [CADDR_WIDTH-1:0] LAST_ENTRY = CADDR_WIDTH'(CACHE_DEPTH-1);

  state_t                  state_q, state_d;
  logic [CADDR_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;

  // Register-array cache: combinational read lets back-to-back beats to one entry chain without a bubble.
  logic [EW-1:0]           cache [CACHE_DEPTH];
  logic [NUM_CH-1:0]       sat_q [CACHE_DEPTH];

  logic                    addr_ok;
  logic                    accept;
  logic [EW-1:0]           rd_entry;
  logic [NUM_CH-1:0]       rd_sat;
  logic [EW-1:0]           acc_new;
  logic [NUM_CH-1:0]       acc_ovf;
  logic [NUM_CH-1:0]       sticky;
  logic [NUM_CH*DATA_WIDTH-1:0] res_dat;
  logic [NUM_CH-1:0]       res_sat;

  logic                    out_valid_q;
  logic [NUM_CH*DATA_WIDTH-1:0] out_data_q;
  logic [CADDR_WIDTH-1:0]  out_addr_q;
  logic [NUM_CH-1:0]       out_sat_q;

  // Out-of-range addresses read as zero and never write.
  assign addr_ok  = {{(32-CADDR_WIDTH){1'b0}}, bus.in_addr} < DEPTH_U;
  assign rd_entry = addr_ok ? cache[bus.in_addr] : '0;
  assign rd_sat   = addr_ok ? sat_q[bus.in_addr] : '0;

  assign bus.in_ready = (state_q == ST_IDLE) && !bus.in_cache_clear && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_addr       = out_addr_q;
  assign bus.out_sat        = out_sat_q;
  assign bus.out_clear_busy = (state_q == ST_CLEAR);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic signed [ACC_WIDTH:0] OUT_MAX = (ACC_WIDTH+1)'((2**(DATA_WIDTH-1))-1);
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;

    logic [PSUM_WIDTH-1:0]        psum;
    logic [DATA_WIDTH-1:0]        bias;
    logic [ACC_WIDTH-1:0]         base;
    logic [ACC_WIDTH:0]           sum;
    logic [ACC_WIDTH-1:0]         acc;
    logic signed [ACC_WIDTH:0]    biased;
    logic signed [ACC_WIDTH:0]    rnd;
    logic signed [ACC_WIDTH:0]    rounded;
    logic signed [ACC_WIDTH:0]    shifted;
    logic signed [ACC_WIDTH:0]    post_relu;
    logic                         clamp_hi;
    logic                         clamp_lo;

    assign psum = bus.in_psum[c*PSUM_WIDTH +: PSUM_WIDTH];
    assign bias = bus.in_bias[c*DATA_WIDTH +: DATA_WIDTH];
    assign base = bus.in_first ? '0 : rd_entry[c*ACC_WIDTH +: ACC_WIDTH];

    // One guard bit catches overflow; differing top bits mean the true sum left the ACC_WIDTH range.
    assign sum        = {base[ACC_WIDTH-1], base}
                      + {{(ACC_WIDTH+1-PSUM_WIDTH){psum[PSUM_WIDTH-1]}}, psum};
    assign acc_ovf[c] = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    assign acc        = !acc_ovf[c]     ? sum[ACC_WIDTH-1:0] :
                        sum[ACC_WIDTH]  ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                          {1'b0, {(ACC_WIDTH-1){1'b1}}};
    assign acc_new[c*ACC_WIDTH +: ACC_WIDTH] = acc;

    // Bias fits in the guard bit, so this add cannot overflow ACC_WIDTH+1.
    assign biased    = {acc[ACC_WIDTH-1], acc}
                     + (bus.in_add_bias ? {{(ACC_WIDTH+1-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias} : '0);
    assign rnd       = (bus.in_shift == 4'd0) ? '0
                     : ({{ACC_WIDTH{1'b0}}, 1'b1} << (bus.in_shift - 4'd1));
    assign rounded   = biased + rnd;
    assign shifted   = rounded >>> bus.in_shift;
    assign post_relu = (bus.in_relu && shifted[ACC_WIDTH]) ? '0 : shifted;
    assign clamp_hi  = post_relu > OUT_MAX;
    assign clamp_lo  = post_relu < OUT_MIN;

    assign res_dat[c*DATA_WIDTH +: DATA_WIDTH] = clamp_hi ? OUT_MAX[DATA_WIDTH-1:0] :
                                                 clamp_lo ? OUT_MIN[DATA_WIDTH-1:0] :
                                                            post_relu[DATA_WIDTH-1:0];
    // A first pass starts a fresh tile, so stale sticky bits are ignored like the cached value.
    assign sticky[c]  = !bus.in_first && rd_sat[c];
    assign res_sat[c] = sticky[c] || acc_ovf[c] || clamp_hi || clamp_lo;
  end

  // State and clear-sweep counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: a clear request in IDLE starts a sweep that ends after the last entry is written.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_cache_clear) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ENTRY) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Cache update: sweep clear, accumulate on non-last beats, auto-clear the entry on the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < CACHE_DEPTH; e++) begin
        cache[e] <= '0;
        sat_q[e] <= '0;
      end
    end else if (state_q == ST_CLEAR) begin
      cache[clr_cnt_q] <= '0;
      sat_q[clr_cnt_q] <= '0;
    end else if (accept && addr_ok) begin
      if (bus.in_last) begin
        cache[bus.in_addr] <= '0;
        sat_q[bus.in_addr] <= '0;
      end else begin
        cache[bus.in_addr] <= acc_new;
        sat_q[bus.in_addr] <= sticky | acc_ovf;
      end
    end
  end

  // Output register: loads on an accepted last beat, holds while stalled, empties once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_sat_q   <= '0;
    end else if (accept && bus.in_last) begin
      out_valid_q <= 1'b1;
      out_data_q  <= res_dat;
      out_addr_q  <= bus.in_addr;
      out_sat_q   <= res_sat;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pu_psum_accum.sv
// Directed bench for pu_psum_accum: accumulation, post-processing, backpressure, clear sweep, reset abort.
// Expected values are hand-computed constants; checks sample at negedge or just after an edge.
// Every input beat wait is bounded and a timeout counts as a miscompare.
module tb_pu_psum_accum;
  localparam int DW = 8;
  localparam int NC = 4;
  localparam int PW = 2*DW+6;
  localparam int AW = PW+4;
  localparam int CD = 32;
  localparam int CW = 5;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  pu_psum_accum_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .PSUM_WIDTH(PW), .CADDR_WIDTH(CW)) bus ();

  pu_psum_accum #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .PSUM_WIDTH(PW), .ACC_WIDTH(AW),
    .CACHE_DEPTH(CD), .CADDR_WIDTH(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC*PW-1:0] ps4(input int a, input int b, input int c, input int d);
    return {PW'(d), PW'(c), PW'(b), PW'(a)};
  endfunction

  function automatic logic [NC*DW-1:0] pk8(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  task automatic set_beat(input int addr, input logic first, input logic last,
                          input logic [NC*PW-1:0] psum, input logic [NC*DW-1:0] bias,
                          input logic add_bias, input logic relu, input logic [3:0] shift);
    bus.in_addr     = CW'(addr);
    bus.in_first    = first;
    bus.in_last     = last;
    bus.in_psum     = psum;
    bus.in_bias     = bias;
    bus.in_add_bias = add_bias;
    bus.in_relu     = relu;
    bus.in_shift    = shift;
  endtask

  // Present the configured beat from just after an edge and hold it until an accepting edge.
  task automatic push(input string tag);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({tag, "_accept_timeout"}, 64'(n), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst                = 1'b1;
    bus.in_valid       = 1'b0;
    bus.in_cache_clear = 1'b0;
    bus.out_ready      = 1'b1;
    set_beat(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 4'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_out_addr",  64'(bus.out_addr),  64'd0);
    chk("rst_out_sat",   64'(bus.out_sat),   64'd0);
    chk("rst_busy",      64'(bus.out_clear_busy), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);

    // Three-pass tile at entry 5: 100+200-50+10 = 260, (260+2)>>2 = 65
    set_beat(5, 1'b1, 1'b0, ps4(100, 0, 0, 0), '0, 1'b0, 1'b0, 4'd0);
    push("t1_b1");
    chk("t1_no_out_b1", 64'(bus.out_valid), 64'd0);
    set_beat(5, 1'b0, 1'b0, ps4(200, 0, 0, 0), '0, 1'b0, 1'b0, 4'd0);
    push("t1_b2");
    set_beat(5, 1'b0, 1'b1, ps4(-50, 0, 0, 0), pk8(10, 0, 0, 0), 1'b1, 1'b0, 4'd2);
    push("t1_b3");
    @(negedge clk);
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_data",  64'(bus.out_data),  64'(pk8(65, 0, 0, 0)));
    chk("t1_addr",  64'(bus.out_addr),  64'd5);
    chk("t1_sat",   64'(bus.out_sat),   64'd0);
    // Entry 5 was auto-cleared by the last beat
    set_beat(5, 1'b0, 1'b1, ps4(0, 0, 0, 0), '0, 1'b0, 1'b0, 4'd0);
    push("t1_rd");
    @(negedge clk);
    chk("t1_autoclr_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_autoclr_data",  64'(bus.out_data),  64'd0);

    // Single-pass tile, ch1 = -300 with ReLU, then without ReLU (clamps to -128)
    set_beat(3, 1'b1, 1'b1, ps4(0, -300, 0, 0), '0, 1'b0, 1'b1, 4'd0);
    push("t2_relu");
    @(negedge clk);
    chk("t2_relu_data", 64'(bus.out_data), 64'(pk8(0, 0, 0, 0)));
    chk("t2_relu_sat",  64'(bus.out_sat),  64'd0);
    set_beat(3, 1'b1, 1'b1, ps4(0, -300, 0, 0), '0, 1'b0, 1'b0, 4'd0);
    push("t2_clamp");
    @(negedge clk);
    chk("t2_clamp_data", 64'(bus.out_data), 64'(pk8(0, -128, 0, 0)));
    chk("t2_clamp_sat",  64'(bus.out_sat),  64'b0010);
    chk("t2_clamp_addr", 64'(bus.out_addr), 64'd3);
    idle(1);

    // Backpressure: output held, second last beat stalls, then accepted on the consuming edge
    bus.out_ready = 1'b0;
    set_beat(7, 1'b1, 1'b1, ps4(50, 0, 0, 0), '0, 1'b0, 1'b0, 4'd0);
    push("t3_a");
    set_beat(9, 1'b1, 1'b1, ps4(-20, 0, 0, 0), '0, 1'b0, 1'b0, 4'd0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("t3_stall_ready", 64'(bus.in_ready), 64'd0);
    chk("t3_hold_data0",  64'(bus.out_data), 64'(pk8(50, 0, 0, 0)));
    repeat (3) @(negedge clk);
    chk("t3_hold_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_hold_data3", 64'(bus.out_data),  64'(pk8(50, 0, 0, 0)));
    chk("t3_hold_addr",  64'(bus.out_addr),  64'd7);
    bus.out_ready = 1'b1;
    #1;
    chk("t3_ready_up", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t3_b_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_b_data",  64'(bus.out_data),  64'(pk8(-20, 0, 0, 0)));
    chk("t3_b_addr",  64'(bus.out_addr),  64'd9);
    idle(1);
    chk("t3_drained", 64'(bus.out_valid), 64'd0);

    // Fill every entry, then sweep-clear; a beat presented with the clear pulse is refused
    for (int i = 0; i < CD; i++) begin
      set_beat(i, 1'b1, 1'b0, ps4(i + 1, 3, 0, 0), '0, 1'b0, 1'b0, 4'd0);
      push("t4_fill");
    end
    set_beat(0, 1'b1, 1'b1, ps4(99, 0, 0, 0), '0, 1'b0, 1'b0, 4'd0);
    bus.in_valid       = 1'b1;
    bus.in_cache_clear = 1'b1;
    #1;
    chk("t4_clr_refuse", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.in_valid       = 1'b0;
    bus.in_cache_clear = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.out_clear_busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("t4_busy_cycles", 64'(n), 64'd32);
    chk("t4_no_output",   64'(bus.out_valid), 64'd0);
    chk("t4_ready_back",  64'(bus.in_ready),  64'd1);
    for (int i = 0; i < CD; i++) begin
      set_beat(i, 1'b0, 1'b1, ps4(0, 0, 0, 0), '0, 1'b0, 1'b0, 4'd0);
      push("t4_rd");
      @(negedge clk);
      chk($sformatf("t4_entry%0d", i), 64'(bus.out_data), 64'd0);
    end
    idle(1);

    // Saturating accumulation: 20 x (2^21-1) pins at 2^25-1; (2^25-1+2^14)>>15 clamps to 127
    for (int i = 0; i < 20; i++) begin
      set_beat(12, (i == 0), (i == 19), ps4(0, 0, (1 << (PW - 1)) - 1, 0), '0,
               1'b0, 1'b0, (i == 19) ? 4'd15 : 4'd0);
      push("t5_acc");
    end
    @(negedge clk);
    chk("t5_data", 64'(bus.out_data), 64'(pk8(0, 0, 127, 0)));
    chk("t5_sat",  64'(bus.out_sat),  64'b0100);

    // Reset mid-sweep with an output pending
    set_beat(20, 1'b1, 1'b0, ps4(0, 0, 0, 77), '0, 1'b0, 1'b0, 4'd0);
    push("t6_fill");
    bus.out_ready = 1'b0;
    set_beat(1, 1'b1, 1'b1, ps4(5, 0, 0, 0), '0, 1'b0, 1'b0, 4'd0);
    push("t6_pend");
    bus.in_cache_clear = 1'b1;
    @(posedge clk); #1;
    bus.in_cache_clear = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_pre_busy",  64'(bus.out_clear_busy), 64'd1);
    chk("t6_pre_valid", 64'(bus.out_valid),      64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(bus.out_valid),      64'd0);
    chk("t6_rst_busy",  64'(bus.out_clear_busy), 64'd0);
    chk("t6_rst_data",  64'(bus.out_data),       64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    set_beat(20, 1'b0, 1'b1, ps4(0, 0, 0, 0), '0, 1'b0, 1'b0, 4'd0);
    push("t6_rd");
    @(negedge clk);
    chk("t6_entry20_data", 64'(bus.out_data), 64'd0);
    chk("t6_entry20_sat",  64'(bus.out_sat),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pu_psum_accum.md
Name: pu_psum_accum

Overview:
- Parametrised partial-sum accumulation and post-processing unit. It is the next-generation back end of the processing unit and sits between the MAC cluster adder trees and the result memory.
- Accepts NUM_CH channel partial sums per beat over a valid/ready handshake and accumulates them into a CACHE_DEPTH-entry register cache.
- On the last pass of a tile it adds a per-channel bias, then applies rounding shift, optional ReLU and saturation to DATA_WIDTH, and emits the result over a valid/ready output.
- Adds features the previous generation lacks: multi-channel operation, a handshake with backpressure, a sequenced cache clear, runtime requantisation and saturation flags.

Parameters:
DATA_WIDTH, 8, output/bias element width
NUM_CH, 4, parallel output channels per beat
PSUM_WIDTH, 2*DATA_WIDTH+6, signed width of each incoming partial sum
ACC_WIDTH, PSUM_WIDTH+4, signed width of each cache accumulator
CACHE_DEPTH, 32, cache entries (each entry holds NUM_CH accumulators)
CADDR_WIDTH, 5, cache address width (2^CADDR_WIDTH >= CACHE_DEPTH)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_psum  in  NUM_CH*PSUM_WIDTH  signed partial sums, channel 0 in LSBs
in_addr  in  CADDR_WIDTH  cache entry for this beat
in_first  in  1  first pass: ignore cached value
in_last  in  1  last pass: post-process and emit
in_add_bias  in  1  1 = add in_bias on last pass
in_relu  in  1  1 = clamp negatives to 0
in_shift  in  4  arithmetic right-shift amount for requantisation
in_bias  in  NUM_CH*DATA_WIDTH  signed per-channel bias
in_cache_clear  in  1  pulse: start cache clear sweep
out_valid  out  1  output beat valid
out_ready  in  1  output beat consumed when out_valid && out_ready
out_data  out  NUM_CH*DATA_WIDTH  signed results
out_addr  out  CADDR_WIDTH  cache entry that produced out_data
out_sat  out  NUM_CH  per-channel flag: accumulation or output saturated
out_clear_busy  out  1  clear sweep in progress

Behaviour:
- Reset (async, rst=1) has these effects:
  - state = IDLE.
  - all cache accumulators = 0.
  - per-entry sat bits = 0.
  - out_valid = 0, out_data = 0, out_addr = 0, out_sat = 0.
  - out_clear_busy = 0.
  - clear counter = 0.
- Reset asserted mid-sweep or mid-output aborts the operation. Any pending output is dropped.
- States:
  - IDLE -> CLEAR when in_cache_clear=1.
  - CLEAR -> IDLE after the cycle that writes entry CACHE_DEPTH-1.
- CLEAR state:
  - Zeroes one entry per cycle, entry 0 first, then ascending.
  - Also clears that entry's sat bits.
  - Lasts exactly CACHE_DEPTH cycles; out_clear_busy=1 throughout.
  - in_cache_clear is ignored while in CLEAR.
- in_ready = (state==IDLE) && !in_cache_clear && (!out_valid || out_ready). The output drains normally during CLEAR.
- On an accepted beat, per channel c:
  - base = in_first ? 0 : cache[in_addr][c].
  - acc = base + sign-extended in_psum[c], saturated to ACC_WIDTH signed.
  - Saturation sets sticky bit sat[in_addr][c].
- Non-last beat: cache[in_addr][c] = acc at the same edge. No output is produced.
- Last beat, at the accept edge:
  - cache[in_addr] and its sat bits are written to 0 (auto-clear for the next tile).
  - The output register loads the post-processed result; out_valid=1 at the next cycle (latency 1).
- Post-processing, per channel, in this order:
  - v = acc + (in_add_bias ? sign-extended in_bias[c] : 0), at ACC_WIDTH+1 bits.
  - If in_shift>0: v = (v + 2^(in_shift-1)) >>> in_shift (round half up).
  - If in_relu and v<0: v = 0.
  - Clamp v to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - out_sat[c] = sticky sat bit || accumulation saturated this beat || clamp active.
- Back-to-back beats to the same address: beat N+1 sees beat N's written value, because the cache is a register array read combinationally. No bubble is required.
- in_first && in_last together is a single-pass tile: base = 0, and the result is emitted.
- Output hold: out_data/out_addr/out_sat stay stable while out_valid && !out_ready.
- out_valid drops after a consuming edge unless a new last beat is accepted at that same edge.
- in_addr >= CACHE_DEPTH: the beat is accepted but the cache write is discarded; the read returns 0.

Test Plan:
- Defaults; reset; then 3 beats to addr 5, ch0 psum = 100, 200, -50, first on beat 1, last on beat 3, bias 10, shift 2, no relu, out_ready=1 -> one output, ch0 = (260+2)>>2 = 65, out_addr=5, out_sat=0. After that, an in_first=0 read of entry 5 yields 0.
- Single beat, first+last, ch1 psum = -300, relu=1 -> ch1 = 0. Same beat without relu, shift 0 -> ch1 = -128, out_sat[1]=1.
- Hold out_ready=0 with an output pending and drive a second last beat -> in_ready=0 and out_data stable. Raise out_ready -> the second beat is accepted at that edge, and out_valid stays 1 with the new data next cycle.
- Fill entries 0..31 with non-zero values, pulse in_cache_clear together with in_valid -> the beat is not accepted, and out_clear_busy=1 for exactly 32 cycles. After the sweep, every entry reads 0 and in_ready returns high.
- Accumulate ch2 psum = +2^(PSUM_WIDTH-1)-1 repeatedly for 20 beats -> the accumulator pins at 2^(ACC_WIDTH-1)-1, and the final output has out_sat[2]=1.
- Assert rst for 1 cycle mid-sweep (cycle 10) and with out_valid=1 -> out_valid=0, out_clear_busy=0 and all entries zero immediately, asynchronously.
